scan_select_gen: RTL

- Sequential select generator sitting directly upstream of the 2-to-4 decoder.
- Drives the decoder enable and the two select bits (i1, i0), stepping through decoder outputs d0..d3 in time slots.
- Guarantees break-before-make: enable is always low while the select changes, so no two decoder outputs are ever high at once.
- Supports free-running scan and single-step operation.

---
 rtl/scan_select_gen_if.sv | 21 ++
 rtl/scan_select_gen.sv | 107 ++++++++++
 2 files changed

// File: rtl/scan_select_gen_if.sv
// Handshake bundle between the scan controller and its 2-to-4 decoder side.
// The master drives run/step; the slave (the generator) drives enable, selects and pulses.
interface scan_select_gen_if;
    logic run;
    logic step;
    logic en;
    logic i1;
    logic i0;
    logic slot_done;
    logic wrap;

    modport master (
        output run, step,
        input  en, i1, i0, slot_done, wrap
    );

    modport slave (
        input  run, step,
        output en, i1, i0, slot_done, wrap
    );
endinterface

// File: rtl/scan_select_gen.sv
// Time-slotted select generator for a 2-to-4 decoder with break-before-make blanking.
// Each slot is DIV cycles: BLANK cycles with enable low, then the rest with enable high.
module scan_select_gen #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned BLANK = 1,
    parameter int unsigned LAST  = 3
) (
    input  logic             clk,
    input  logic             rst,
    scan_select_gen_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_ACTIVE
    } state_e;

    localparam logic [7:0] DivEnd   = 8'(DIV - 1);
    localparam logic [7:0] BlankEnd = 8'(BLANK - 1);
    localparam logic [1:0] LastIdx  = 2'(LAST);

    state_e     state_q, state_d;
    logic [7:0] presc_q, presc_d;
    logic [1:0] idx_q, idx_d;
    logic       single_q, single_d;
    logic       en_q, en_d;
    logic       done_q, done_d;
    logic       wrap_q, wrap_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            idx_q    <= '0;
            single_q <= 1'b0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            single_q <= single_d;
            en_q     <= en_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        idx_d    = idx_q;
        single_d = single_q;

        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d  = S_BLANK;
                    presc_d  = '0;
                    single_d = 1'b0;
                end else if (bus.step) begin
                    state_d  = S_BLANK;
                    presc_d  = '0;
                    single_d = 1'b1;
                end
            end
            S_BLANK: begin
                presc_d = presc_q + 8'd1;
                if (presc_q == BlankEnd) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                // The select only moves here, while enable is about to drop.
                if (presc_q == DivEnd) begin
                    presc_d = '0;
                    idx_d   = (idx_q == LastIdx) ? 2'd0 : idx_q + 2'd1;
                    if (bus.run && !single_q) begin
                        state_d = S_BLANK;
                    end else begin
                        state_d  = S_IDLE;
                        single_d = 1'b0;
                    end
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from next-state so they line up with the state they describe.
        en_d   = (state_d == S_ACTIVE);
        done_d = en_d && (presc_d == DivEnd);
        wrap_d = done_d && (idx_d == LastIdx);
    end

    assign bus.en        = en_q;
    assign bus.i1        = idx_q[1];
    assign bus.i0        = idx_q[0];
    assign bus.slot_done = done_q;
    assign bus.wrap      = wrap_q;

endmodule
